// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse packet types for the transmit serializer and receive-side framer.
package ps2_pkg;

  localparam int unsigned PS2_BYTE_W   = 8;
  localparam int unsigned PS2_PKT_W    = 3 * PS2_BYTE_W;
  localparam int unsigned PS2_SYNC_BIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } ps2_tx_state_t;

  // Byte 1 occupies the most significant bits so the struct matches the flat bus.
  typedef struct packed {
    logic [PS2_BYTE_W-1:0] b1;
    logic [PS2_BYTE_W-1:0] b2;
    logic [PS2_BYTE_W-1:0] b3;
  } ps2_pkt_t;

endpackage

// File: rtl/ps2_pkt_buf.sv
// One-entry packet holding register with full flag; load wins over unload.
module ps2_pkt_buf
  import ps2_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  logic     load_i,
  input  ps2_pkt_t data_i,
  input  logic     unload_i,
  output logic     full_o,
  output ps2_pkt_t data_o
);

  logic     full_q, full_d;
  ps2_pkt_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/ps2_packet_tx.sv
// PS/2 mouse packet serializer: 24-bit packets in, byte stream out (byte 1 first),
// with a one-packet holding buffer so consecutive packets stream without bubbles.
module ps2_packet_tx
  import ps2_pkg::*;
#(
  parameter bit          FORCE_SYNC = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [PS2_PKT_W-1:0]  pkt_data,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  output logic [PS2_BYTE_W-1:0] out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  sync_err,
  output logic [CNT_W-1:0]      tx_count
);

  ps2_tx_state_t state_q, state_d;
  ps2_pkt_t      cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [PS2_BYTE_W-1:0] out_byte_q, out_byte_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;

  logic     buf_full, buf_load, buf_unload;
  ps2_pkt_t buf_data, in_pkt;
  logic     accept, sync_ok, good_acc, xfer;

  ps2_pkt_buf u_buf (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (buf_load),
    .data_i   (in_pkt),
    .unload_i (buf_unload),
    .full_o   (buf_full),
    .data_o   (buf_data)
  );

  assign pkt_ready = !buf_full && resetn;
  assign accept    = pkt_valid && pkt_ready;
  assign sync_ok   = FORCE_SYNC || pkt_data[2*PS2_BYTE_W + PS2_SYNC_BIT];
  assign good_acc  = accept && sync_ok;
  assign xfer      = out_valid_q && out_ready;

  // Incoming packet with the sync bit forced when configured to repair it.
  always_comb begin
    in_pkt = ps2_pkt_t'(pkt_data);
    if (FORCE_SYNC) in_pkt.b1[PS2_SYNC_BIT] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    err_d      = accept && !sync_ok;

    case (state_q)
      IDLE: begin
        if (good_acc) begin
          cur_d   = in_pkt;
          state_d = BYTE1;
        end
      end
      BYTE1: begin
        buf_load = good_acc;
        if (xfer) state_d = BYTE2;
      end
      BYTE2: begin
        buf_load = good_acc;
        if (xfer) state_d = BYTE3;
      end
      BYTE3: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Buffered packet has priority; buffer full implies no accept this cycle.
          if (buf_full) begin
            cur_d      = buf_data;
            buf_unload = 1'b1;
            state_d    = BYTE1;
          end else if (good_acc) begin
            cur_d   = in_pkt;
            state_d = BYTE1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          buf_load = good_acc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output registers follow the next state so byte 1 appears the cycle after the load.
    out_valid_d = (state_d != IDLE);
    out_first_d = (state_d == BYTE1);
    out_last_d  = (state_d == BYTE3);
    case (state_d)
      BYTE1:   out_byte_d = cur_d.b1;
      BYTE2:   out_byte_d = cur_d.b2;
      BYTE3:   out_byte_d = cur_d.b3;
      default: out_byte_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign sync_err  = err_q;
  assign tx_count  = cnt_q;

endmodule

// File: tb/tb_ps2_packet_tx.sv
// Bench for ps2_packet_tx: packet-queue reference model plus directed literal checks.
module tb_ps2_packet_tx;
  import ps2_pkg::*;

  localparam int unsigned CW0 = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // dut0: FORCE_SYNC=0, 2-bit counter (wrap test)
  logic [23:0] pkt_data;
  logic        pkt_valid, pkt_ready;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready, out_first, out_last, sync_err;
  logic [CW0-1:0] tx_count;

  // dut1: FORCE_SYNC=1, default counter width
  logic [23:0] p1_data;
  logic        p1_valid, p1_ready;
  logic [7:0]  o1_byte;
  logic        o1_valid, o1_ready, o1_first, o1_last, e1_err;
  logic [15:0] c1_count;

  ps2_packet_tx #(.FORCE_SYNC(1'b0), .CNT_W(CW0)) dut0 (
    .clk(clk), .resetn(resetn), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .sync_err(sync_err), .tx_count(tx_count)
  );

  ps2_packet_tx #(.FORCE_SYNC(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .resetn(resetn), .pkt_data(p1_data), .pkt_valid(p1_valid),
    .pkt_ready(p1_ready), .out_byte(o1_byte), .out_valid(o1_valid),
    .out_ready(o1_ready), .out_first(o1_first), .out_last(o1_last),
    .sync_err(e1_err), .tx_count(c1_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of stored packets (in flight + held) and byte index of the head.
  logic [23:0] mq[$];
  int          idx     = 0;
  int          mcount  = 0;
  bit          merr    = 1'b0;
  bit          started = 1'b0;
  bit          m_acc;

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      idx     = 0;
      mcount  = 0;
      merr    = 1'b0;
      started = 1'b1;
    end else if (started) begin
      m_acc = pkt_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) begin
        idx++;
        if (idx == 3) begin
          void'(mq.pop_front());
          idx = 0;
          mcount++;
        end
      end
      merr = m_acc && !pkt_data[16 + PS2_SYNC_BIT];
      if (m_acc && pkt_data[16 + PS2_SYNC_BIT]) mq.push_back(pkt_data);
    end
  end

  // Per-cycle compare, loopback reassembly and valid-run tracking.
  logic [23:0] asm_pkt = '0;
  logic [23:0] head;
  logic [7:0]  exp_b;
  int          run = 0;
  int          run_max = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("pkt_ready", 32'(pkt_ready), 32'(resetn && (mq.size() < 2)));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("sync_err", 32'(sync_err), 32'(merr));
      chk("tx_count", 32'(tx_count), 32'(mcount % (1 << CW0)));
      if (mq.size() > 0) begin
        head  = mq[0];
        exp_b = (idx == 0) ? head[23:16] : (idx == 1) ? head[15:8] : head[7:0];
        chk("out_byte", 32'(out_byte), 32'(exp_b));
        chk("out_first", 32'(out_first), 32'(idx == 0));
        chk("out_last", 32'(out_last), 32'(idx == 2));
        if (out_valid && out_ready) begin
          if (out_first) asm_pkt = {out_byte, 16'h0000};
          else if (out_last) begin
            asm_pkt[7:0] = out_byte;
            chk("loopback", 32'(asm_pkt), 32'(head));
          end else asm_pkt[15:8] = out_byte;
        end
      end
      if (out_valid) run++;
      else run = 0;
      if (run > run_max) run_max = run;
    end
  end

  task automatic send(input logic [23:0] d);
    int n;
    n = 0;
    pkt_data  = d;
    pkt_valid = 1'b1;
    @(negedge clk);
    while (!pkt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(pkt_ready), 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; pkt_data = '0; out_ready = 1'b1;
    p1_valid = 1'b0; p1_data = '0; o1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    chk("rst_ready", 32'(pkt_ready), 32'd0);
    chk("rst_count", 32'(tx_count), 32'd0);
    @(posedge clk); #2 resetn = 1'b1;

    // Single packet
    send(24'h081234); pkt_valid = 1'b0;
    @(negedge clk);
    chk("s1_b1", 32'(out_byte), 32'h08); chk("s1_first", 32'(out_first), 32'd1);
    @(negedge clk);
    chk("s1_b2", 32'(out_byte), 32'h12);
    @(negedge clk);
    chk("s1_b3", 32'(out_byte), 32'h34); chk("s1_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("s1_idle", 32'(out_valid), 32'd0); chk("s1_count", 32'(tx_count), 32'd1);

    // Back-to-back: 9 contiguous bytes, counter wraps 4 -> 0
    @(posedge clk); #2 run_max = 0;
    send(24'h18A1B2); send(24'h28C3D4); send(24'h3FE5F6); pkt_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_run", 32'(run_max), 32'd9);
    chk("b2b_wrap", 32'(tx_count), 32'd0);

    // Backpressure during byte 2
    @(posedge clk); #2;
    send(24'h081234); pkt_valid = 1'b0;
    @(negedge clk);
    chk("bp_b1", 32'(out_byte), 32'h08);
    @(posedge clk); #2 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", 32'(out_byte), 32'h12);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_count", 32'(tx_count), 32'd1);

    // Bad sync bit dropped
    @(posedge clk); #2;
    send(24'h00AABB); pkt_valid = 1'b0;
    @(negedge clk);
    chk("se_pulse", 32'(sync_err), 32'd1); chk("se_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("se_clear", 32'(sync_err), 32'd0); chk("se_count", 32'(tx_count), 32'd1);

    // Forced sync bit on dut1
    @(posedge clk); #2 p1_data = 24'h00AABB; p1_valid = 1'b1;
    @(negedge clk);
    chk("fs_ready", 32'(p1_ready), 32'd1);
    @(posedge clk); #2 p1_valid = 1'b0;
    @(negedge clk);
    chk("fs_b1", 32'(o1_byte), 32'h08); chk("fs_first", 32'(o1_first), 32'd1);
    @(negedge clk);
    chk("fs_b2", 32'(o1_byte), 32'hAA);
    @(negedge clk);
    chk("fs_b3", 32'(o1_byte), 32'hBB); chk("fs_last", 32'(o1_last), 32'd1);
    @(negedge clk);
    chk("fs_count", 32'(c1_count), 32'd1); chk("fs_err", 32'(e1_err), 32'd0);

    // Reset during byte 2 with the buffer full
    @(posedge clk); #2;
    send(24'h085566); pkt_valid = 1'b0;
    @(posedge clk); #2 out_ready = 1'b0;
    send(24'h187788); pkt_valid = 1'b0;
    @(negedge clk);
    chk("rs_pre_ready", 32'(pkt_ready), 32'd0); chk("rs_pre_b2", 32'(out_byte), 32'h55);
    @(posedge clk); #2 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rs_valid", 32'(out_valid), 32'd0); chk("rs_byte", 32'(out_byte), 32'd0);
    chk("rs_first", 32'(out_first), 32'd0); chk("rs_last", 32'(out_last), 32'd0);
    chk("rs_count", 32'(tx_count), 32'd0); chk("rs_ready", 32'(pkt_ready), 32'd0);
    chk("rs_err", 32'(sync_err), 32'd0);
    @(posedge clk); #2 resetn = 1'b1; out_ready = 1'b1;
    send(24'h0F5A5A); pkt_valid = 1'b0;
    @(negedge clk);
    chk("rs_next_b1", 32'(out_byte), 32'h0F); chk("rs_next_first", 32'(out_first), 32'd1);
    repeat (4) @(negedge clk);
    chk("rs_next_count", 32'(tx_count), 32'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_packet_tx.md
# ps2_packet_tx

Transmit-side PS/2 mouse packet serializer. Accepts whole 24-bit packets (byte 1 in bits [23:16], byte 3 in [7:0]) over a valid/ready handshake and emits them as a byte stream, one byte per handshake, byte 1 first. It is the counterpart of the byte-stream packet framer: its output, fed to the framer, reproduces the same 24-bit packets with `done` asserted. It has a one-packet holding buffer, so back-to-back packets stream with no idle cycle.

## Interface
- `FORCE_SYNC`, default 0; 1 = force byte-1 bit 3 to 1; 0 = drop packets whose byte-1 bit 3 is 0.
- `CNT_W`, default 16; width of the sent-packet counter.

- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `pkt_data`  in  24  packet; [23:16]=byte 1, [15:8]=byte 2, [7:0]=byte 3.
- `pkt_valid`  in  1  packet offered.
- `pkt_ready`  out  1  packet can be accepted.
- `out_byte`  out  8  current byte.
- `out_valid`  out  1  `out_byte` valid.
- `out_ready`  in  1  downstream takes byte.
- `out_first`  out  1  high with `out_valid` on byte 1.
- `out_last`  out  1  high with `out_valid` on byte 3.
- `sync_err`  out  1  one-cycle pulse: packet dropped (FORCE_SYNC=0 only).
- `tx_count`  out  CNT_W  packets fully sent; wraps modulo 2^CNT_W.

## Operation
- Accept = `pkt_valid && pkt_ready`; byte transfer = `out_valid && out_ready`.
- FSM states: IDLE, BYTE1, BYTE2, BYTE3.
  - IDLE: `out_valid`=0. Accept of a good packet loads the current register -> BYTE1.
  - BYTE1 -> BYTE2 -> BYTE3 on each transfer; no change without a transfer.
  - BYTE3 transfer: if the holding buffer is full, move it to the current register and go to BYTE1. Else, if an accept happens in the same cycle, load the input directly and go to BYTE1. Otherwise go to IDLE.
- `pkt_ready` = holding buffer empty and `resetn`=1. Accept outside IDLE fills the holding buffer, unless the BYTE3-transfer direct-load rule applies.
- Sync check on `pkt_data[19]`:
  - FORCE_SYNC=1: store with bit 19 set.
  - FORCE_SYNC=0 and bit 19 = 0: complete the handshake, discard the packet, pulse `sync_err` the next cycle. Nothing stored, no count.
- `out_byte`, `out_first` and `out_last` are stable while `out_valid && !out_ready`.
- `tx_count` increments on the BYTE3 transfer; wraps from all-ones to 0.

## Timing
- Reset (`resetn`=0 at an edge): state IDLE, holding buffer empty, `out_valid`=0, `out_first`=0, `out_last`=0, `out_byte`=0, `sync_err`=0, `tx_count`=0. `pkt_ready`=0 while `resetn` is low.
- Reset mid-packet: the packet and buffer are abandoned; no partial bytes follow.
- Latency: accept in IDLE at edge N gives byte 1 valid after edge N (cycle N+1). With `out_ready` held at 1, a packet takes exactly 3 cycles; back-to-back packets give 3k contiguous valid cycles.
- `sync_err` is registered: high for exactly the one cycle after the dropping accept.
- Output registers are driven from the current register and state only; no combinational path from `pkt_*` to `out_*`.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_tx_state_t` {IDLE, BYTE1, BYTE2, BYTE3};
  - `PS2_SYNC_BIT`=3;
  - `ps2_pkt_t` typedef (24-bit packed, fields b1/b2/b3);
  - shared with the receive-side framer.
- Sub-module `ps2_pkt_buf`: one-entry holding register with full flag, load/unload ports. FSM, sync check and counter stay in the top module.

## Test plan
- Single packet 0x08_12_34, `out_ready`=1 -> bytes 0x08, 0x12, 0x34 on cycles N+1..N+3; `out_first` on 0x08, `out_last` on 0x34; `tx_count`=1.
- Three back-to-back packets, `out_ready`=1 -> 9 contiguous valid bytes, no bubble; `pkt_ready` drops while the buffer is full; `tx_count`=3.
- Backpressure: `out_ready`=0 for 5 cycles during byte 2 -> `out_byte` holds 0x12 with `out_valid`=1; the stream resumes intact.
- Packet 0x00_AA_BB: FORCE_SYNC=0 -> no bytes, `sync_err` pulses 1 cycle, count unchanged. FORCE_SYNC=1 -> bytes 0x08, 0xAA, 0xBB.
- `resetn` low during byte 2 with the buffer full -> next cycle all outputs at reset values; the next packet starts cleanly at byte 1. Loopback into the framer -> `done` with `out_bytes` equal to the sent packet; `tx_count` wraps to 0 at 2^CNT_W (test with CNT_W=2).
